// File: rtl/cl_tx_framer_if.sv
// AXI-Stream video beat bundle: tuser marks start of frame, tlast marks end of line.
interface cl_tx_framer_if #(
    parameter int unsigned W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cl_tx_framer.sv
// Camera Link transmit framer: AXI-Stream video in, 28-bit Channel Link word out
// with programmable frame/line blanking and sticky underrun/sync error flags.
module cl_tx_framer #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 16,
    parameter int unsigned FV_TO_LV             = 4,
    parameter int unsigned HBLANK               = 8,
    parameter int unsigned LV_TO_FV             = 4,
    parameter int unsigned VBLANK               = 16
) (
    input  logic                CL_clk,
    input  logic                CL_reset,
    input  logic                Enable,
    input  logic [15:0]         LineSize,
    input  logic [15:0]         FrameSize,
    input  logic                ErrClear,
    cl_tx_framer_if.slave       S00_AXIS,
    output logic [27:0]         CL_data,
    output logic                Busy,
    output logic [15:0]         FrameCount,
    output logic                UnderrunErr,
    output logic                SyncErr
);
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 24;

    typedef enum logic [2:0] {
        S_IDLE, S_FV_LEAD, S_LINE, S_HBLANK, S_FV_TAIL, S_VBLANK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic [CW-1:0]   pix_q, pix_d;
    logic [CW-1:0]   line_q, line_d;
    logic [CW-1:0]   lsize_q, lsize_d;
    logic [CW-1:0]   fsize_q, fsize_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic [PW-1:0]   pixel_q, pixel_d;
    logic            lval_q, lval_d;
    logic            fval_q, fval_d;
    logic            dval_q, dval_d;
    logic            busy_q, busy_d;
    logic            under_q, under_d;
    logic            sync_q, sync_d;
    logic            under_set, sync_set;
    logic            tready_c;
    logic            en_ok_c;
    logic            last_pix_c;
    logic            first_pix_c;
    logic [CW-1:0]   line_nxt_c;

    assign en_ok_c     = Enable && (LineSize != '0) && (FrameSize != '0);
    assign last_pix_c  = (pix_q == CW'(lsize_q - 16'd1));
    assign first_pix_c = (pix_q == '0) && (line_q == '0);
    assign line_nxt_c  = CW'(line_q + 16'd1);

    // Ready is combinational so the SOF beat is held back in IDLE and consumed as pixel 0.
    assign S00_AXIS.tready = tready_c && !CL_reset;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        pix_d     = pix_q;
        line_d    = line_q;
        lsize_d   = lsize_q;
        fsize_d   = fsize_q;
        fcnt_d    = fcnt_q;
        pixel_d   = pixel_q;
        dval_d    = 1'b0;
        tready_c  = 1'b0;
        under_set = 1'b0;
        sync_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_ok_c) begin
                    tready_c = !(S00_AXIS.tvalid && S00_AXIS.tuser);
                    if (S00_AXIS.tvalid && S00_AXIS.tuser) begin
                        lsize_d = LineSize;
                        fsize_d = FrameSize;
                        tmr_d   = '0;
                        pix_d   = '0;
                        line_d  = '0;
                        state_d = S_FV_LEAD;
                    end
                end
            end
            S_FV_LEAD: begin
                if (tmr_q == CW'(FV_TO_LV - 1)) begin
                    tmr_d   = '0;
                    state_d = S_LINE;
                end else begin
                    tmr_d = CW'(tmr_q + 16'd1);
                end
            end
            S_LINE: begin
                tready_c = 1'b1;
                if (S00_AXIS.tvalid) begin
                    dval_d  = 1'b1;
                    pixel_d = PW'(S00_AXIS.tdata[C_S_AXIS_TDATA_WIDTH-1:0]);
                    if ((S00_AXIS.tlast != last_pix_c) || (S00_AXIS.tuser != first_pix_c)) begin
                        sync_set = 1'b1;
                    end
                    if (last_pix_c) begin
                        pix_d   = '0;
                        line_d  = line_nxt_c;
                        tmr_d   = '0;
                        state_d = (line_nxt_c == fsize_q) ? S_FV_TAIL : S_HBLANK;
                    end else begin
                        pix_d = CW'(pix_q + 16'd1);
                    end
                end else begin
                    under_set = 1'b1;
                end
            end
            S_HBLANK: begin
                if (tmr_q == CW'(HBLANK - 1)) begin
                    tmr_d   = '0;
                    state_d = S_LINE;
                end else begin
                    tmr_d = CW'(tmr_q + 16'd1);
                end
            end
            S_FV_TAIL: begin
                if (tmr_q == CW'(LV_TO_FV - 1)) begin
                    tmr_d   = '0;
                    fcnt_d  = CW'(fcnt_q + 16'd1);
                    state_d = S_VBLANK;
                end else begin
                    tmr_d = CW'(tmr_q + 16'd1);
                end
            end
            S_VBLANK: begin
                if (tmr_q == CW'(VBLANK - 1)) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = CW'(tmr_q + 16'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sync bits follow the current state so they line up with the registered pixel.
        lval_d  = (state_q == S_LINE);
        fval_d  = (state_q == S_FV_LEAD) || (state_q == S_LINE) ||
                  (state_q == S_HBLANK)  || (state_q == S_FV_TAIL);
        busy_d  = (state_d != S_IDLE);
        under_d = under_set || (under_q && !ErrClear);
        sync_d  = sync_set  || (sync_q  && !ErrClear);
    end

    always_ff @(posedge CL_clk) begin
        if (CL_reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            lsize_q <= '0;
            fsize_q <= '0;
            fcnt_q  <= '0;
            pixel_q <= '0;
            lval_q  <= 1'b0;
            fval_q  <= 1'b0;
            dval_q  <= 1'b0;
            busy_q  <= 1'b0;
            under_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            lsize_q <= lsize_d;
            fsize_q <= fsize_d;
            fcnt_q  <= fcnt_d;
            pixel_q <= pixel_d;
            lval_q  <= lval_d;
            fval_q  <= fval_d;
            dval_q  <= dval_d;
            busy_q  <= busy_d;
            under_q <= under_d;
            sync_q  <= sync_d;
        end
    end

    assign CL_data     = {1'b0, dval_q, fval_q, lval_q, pixel_q};
    assign Busy        = busy_q;
    assign FrameCount  = fcnt_q;
    assign UnderrunErr = under_q;
    assign SyncErr     = sync_q;
endmodule

// File: tb/tb_cl_tx_framer.sv
// Directed bench for cl_tx_framer: drives a beat queue, records CL_data per cycle, checks traces.
module tb_cl_tx_framer;
    logic        clk;
    logic        CL_reset;
    logic        Enable;
    logic [15:0] LineSize;
    logic [15:0] FrameSize;
    logic        ErrClear;
    logic [27:0] CL_data;
    logic        Busy;
    logic [15:0] FrameCount;
    logic        UnderrunErr;
    logic        SyncErr;

    cl_tx_framer_if #(.W(16)) ax ();

    cl_tx_framer #(
        .C_S_AXIS_TDATA_WIDTH(16), .FV_TO_LV(4), .HBLANK(8), .LV_TO_FV(4), .VBLANK(16)
    ) dut (
        .CL_clk(clk), .CL_reset(CL_reset), .Enable(Enable), .LineSize(LineSize),
        .FrameSize(FrameSize), .ErrClear(ErrClear), .S00_AXIS(ax), .CL_data(CL_data),
        .Busy(Busy), .FrameCount(FrameCount), .UnderrunErr(UnderrunErr), .SyncErr(SyncErr)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       src[$];
    logic [27:0] trace[$];
    logic [23:0] pix[$];
    int          wins[$];
    int          fv_rise[$];
    int          fv_fall[$];
    int          n_fval, n_lval, n_dval, n_b27;
    int          checks = 0;
    int          errors = 0;
    int          exp_fc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_head();
        if (src.size() > 0) begin
            ax.tvalid = src[0].v;
            ax.tdata  = src[0].d;
            ax.tlast  = src[0].last;
            ax.tuser  = src[0].user;
        end else begin
            ax.tvalid = 1'b0;
            ax.tdata  = '0;
            ax.tlast  = 1'b0;
            ax.tuser  = 1'b0;
        end
    endtask

    // One clock: handshake seen before the edge pops the source; gap entries last one cycle.
    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = ax.tvalid && ax.tready;
        @(posedge clk);
        #1;
        if (src.size() > 0 && (acc || !src[0].v)) void'(src.pop_front());
        trace.push_back(CL_data);
        drive_head();
    endtask

    task automatic push_frame(input int ls, input int fs, input logic [15:0] base);
        beat_t b;
        for (int l = 0; l < fs; l++) begin
            for (int p = 0; p < ls; p++) begin
                b.v    = 1'b1;
                b.d    = base + 16'(l * ls + p);
                b.user = (l == 0 && p == 0);
                b.last = (p == ls - 1);
                src.push_back(b);
            end
        end
    endtask

    task automatic run_frame(output bit to);
        int  n = 0;
        bit  started = 0;
        bit  done = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
            if (Busy) started = 1;
            else if (started) done = 1;
        end
        to = !done;
    endtask

    task automatic pulse_clear();
        ErrClear = 1'b1;
        tick();
        ErrClear = 1'b0;
        tick();
    endtask

    task automatic analyze();
        bit pl = 0, pf = 0;
        int cur = 0;
        n_fval = 0; n_lval = 0; n_dval = 0; n_b27 = 0;
        pix.delete(); wins.delete(); fv_rise.delete(); fv_fall.delete();
        for (int i = 0; i < trace.size(); i++) begin
            logic [27:0] w;
            w = trace[i];
            if (w[25]) n_fval++;
            if (w[24]) n_lval++;
            if (w[27]) n_b27++;
            if (w[26]) begin n_dval++; pix.push_back(w[23:0]); end
            if (w[24]) cur++;
            else if (pl) begin wins.push_back(cur); cur = 0; end
            if (w[25] && !pf) fv_rise.push_back(i);
            if (!w[25] && pf) fv_fall.push_back(i);
            pl = w[24];
            pf = w[25];
        end
        if (pl) wins.push_back(cur);
    endtask

    task automatic test_reset();
        CL_reset = 1'b1;
        Enable   = 1'b1;
        repeat (3) tick();
        checks++; if (CL_data !== 28'h0) begin errors++; $display("FAIL reset_cl_data got %h want 0", CL_data); end
        checks++; if (ax.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", ax.tready); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (FrameCount !== 16'd0) begin errors++; $display("FAIL reset_framecount got %0d want 0", FrameCount); end
        checks++; if (UnderrunErr !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", UnderrunErr); end
        checks++; if (SyncErr !== 1'b0) begin errors++; $display("FAIL reset_syncerr got %b want 0", SyncErr); end
        CL_reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        int seen = 0, n = 0;
        bit prev = 0;
        trace.delete();
        LineSize = 16'd4; FrameSize = 16'd2;
        push_frame(4, 2, 16'h0AA0);
        drive_head();
        while (seen < 2 && n < 200) begin
            tick();
            n++;
            if (trace[trace.size()-1][24] && !prev) seen++;
            prev = trace[trace.size()-1][24];
        end
        checks++; if (seen != 2) begin errors++; $display("FAIL midreset_reach_line1 got %0d lines want 2", seen); end
        CL_reset = 1'b1;
        tick();
        checks++; if (CL_data !== 28'h0) begin errors++; $display("FAIL midreset_cl_data got %h want 0", CL_data); end
        checks++; if (ax.tready !== 1'b0) begin errors++; $display("FAIL midreset_tready got %b want 0", ax.tready); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", Busy); end
        checks++; if (FrameCount !== 16'(exp_fc)) begin errors++; $display("FAIL midreset_framecount got %0d want %0d", FrameCount, exp_fc); end
        CL_reset = 1'b0;
        src.delete();
        drive_head();
        repeat (3) tick();
        checks++; if (CL_data !== 28'h0) begin errors++; $display("FAIL midreset_stays_idle got %h want 0", CL_data); end
    endtask

    task automatic test_basic();
        bit to;
        int bad = 0;
        trace.delete();
        LineSize = 16'd4; FrameSize = 16'd2;
        push_frame(4, 2, 16'h0100);
        drive_head();
        run_frame(to);
        analyze();
        exp_fc++;
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
        checks++; if (n_fval != 24) begin errors++; $display("FAIL basic_fval_cycles got %0d want 24", n_fval); end
        checks++; if (wins.size() != 2 || wins[0] != 4 || wins[1] != 4) begin errors++; $display("FAIL basic_lval_windows got %0d windows want 2 of 4", wins.size()); end
        checks++; if (n_dval != n_lval || n_dval != 8) begin errors++; $display("FAIL basic_dval got %0d lval %0d want 8/8", n_dval, n_lval); end
        for (int i = 0; i < pix.size(); i++) if (pix[i] !== 24'(16'h0100 + 16'(i))) bad++;
        checks++; if (bad != 0 || pix.size() != 8) begin errors++; $display("FAIL basic_pixels got %0d wrong of %0d want 0 of 8", bad, pix.size()); end
        checks++; if (fv_rise.size() < 1 || fv_rise[0] != 1) begin errors++; $display("FAIL basic_fval_start got %0d want 1", fv_rise.size() > 0 ? fv_rise[0] : -1); end
        checks++; if (n_b27 != 0) begin errors++; $display("FAIL basic_bit27 got %0d want 0", n_b27); end
        checks++; if (FrameCount !== 16'(exp_fc)) begin errors++; $display("FAIL basic_framecount got %0d want %0d", FrameCount, exp_fc); end
        checks++; if (UnderrunErr !== 1'b0 || SyncErr !== 1'b0) begin errors++; $display("FAIL basic_errors got %b%b want 00", UnderrunErr, SyncErr); end
    endtask

    task automatic test_underrun();
        bit to;
        int bad = 0;
        beat_t gap;
        gap = '0;
        trace.delete();
        LineSize = 16'd4; FrameSize = 16'd2;
        push_frame(4, 2, 16'h0200);
        src.insert(2, gap);
        src.insert(2, gap);
        drive_head();
        run_frame(to);
        analyze();
        exp_fc++;
        checks++; if (to) begin errors++; $display("FAIL underrun_timeout got busy want idle"); end
        checks++; if (wins.size() != 2 || wins[0] != 6 || wins[1] != 4) begin errors++; $display("FAIL underrun_lval_windows got %0d windows want 6,4", wins.size()); end
        checks++; if (n_lval - n_dval != 2) begin errors++; $display("FAIL underrun_dval_low got %0d want 2", n_lval - n_dval); end
        checks++; if (n_fval != 26) begin errors++; $display("FAIL underrun_fval_cycles got %0d want 26", n_fval); end
        for (int i = 0; i < pix.size(); i++) if (pix[i] !== 24'(16'h0200 + 16'(i))) bad++;
        checks++; if (bad != 0 || pix.size() != 8) begin errors++; $display("FAIL underrun_pixels got %0d wrong of %0d want 0 of 8", bad, pix.size()); end
        checks++; if (UnderrunErr !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", UnderrunErr); end
        checks++; if (SyncErr !== 1'b0) begin errors++; $display("FAIL underrun_syncerr got %b want 0", SyncErr); end
        pulse_clear();
        checks++; if (UnderrunErr !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", UnderrunErr); end
    endtask

    task automatic test_resync();
        bit to;
        int bad = 0;
        beat_t junk;
        trace.delete();
        LineSize = 16'd3; FrameSize = 16'd1;
        for (int i = 0; i < 3; i++) begin
            junk.v = 1'b1; junk.d = 16'hDEA0 + 16'(i); junk.last = 1'b0; junk.user = 1'b0;
            src.push_back(junk);
        end
        push_frame(3, 1, 16'h0050);
        drive_head();
        run_frame(to);
        analyze();
        exp_fc++;
        checks++; if (to) begin errors++; $display("FAIL resync_timeout got busy want idle"); end
        checks++; if (fv_rise.size() != 1 || fv_rise[0] != 4) begin errors++; $display("FAIL resync_fval_start got %0d want 4", fv_rise.size() > 0 ? fv_rise[0] : -1); end
        for (int i = 0; i < pix.size(); i++) if (pix[i] !== 24'(16'h0050 + 16'(i))) bad++;
        checks++; if (bad != 0 || pix.size() != 3) begin errors++; $display("FAIL resync_pixels got %0d wrong of %0d want 0 of 3", bad, pix.size()); end
        checks++; if (n_fval != 11) begin errors++; $display("FAIL resync_fval_cycles got %0d want 11", n_fval); end
        checks++; if (SyncErr !== 1'b0) begin errors++; $display("FAIL resync_syncerr got %b want 0", SyncErr); end
    endtask

    task automatic test_sync_err();
        bit to;
        trace.delete();
        LineSize = 16'd4; FrameSize = 16'd1;
        push_frame(4, 1, 16'h0400);
        src[2].last = 1'b1;
        src[3].last = 1'b0;
        drive_head();
        run_frame(to);
        analyze();
        exp_fc++;
        checks++; if (to) begin errors++; $display("FAIL syncerr_timeout got busy want idle"); end
        checks++; if (SyncErr !== 1'b1) begin errors++; $display("FAIL syncerr_flag got %b want 1", SyncErr); end
        checks++; if (wins.size() != 1 || wins[0] != 4 || n_dval != 4) begin errors++; $display("FAIL syncerr_line got %0d windows %0d dval want 1 and 4", wins.size(), n_dval); end
        checks++; if (n_fval != 12) begin errors++; $display("FAIL syncerr_fval_cycles got %0d want 12", n_fval); end
        pulse_clear();
        checks++; if (SyncErr !== 1'b0) begin errors++; $display("FAIL syncerr_clear got %b want 0", SyncErr); end
        checks++; if (FrameCount !== 16'(exp_fc)) begin errors++; $display("FAIL syncerr_framecount got %0d want %0d", FrameCount, exp_fc); end
    endtask

    task automatic test_back_to_back();
        int  n = 0, rises = 0, gap = -1;
        bit  prevb, to = 0;
        trace.delete();
        LineSize = 16'd2; FrameSize = 16'd1;
        push_frame(2, 1, 16'h0300);
        push_frame(2, 1, 16'h0310);
        push_frame(2, 1, 16'h0320);
        drive_head();
        prevb = Busy;
        while (rises < 2 && n < 500) begin
            tick();
            n++;
            if (Busy && !prevb) rises++;
            prevb = Busy;
        end
        if (rises < 2) to = 1;
        Enable = 1'b0;
        while (Busy && n < 1000) begin
            tick();
            n++;
        end
        if (Busy) to = 1;
        repeat (40) tick();
        analyze();
        exp_fc += 2;
        if (fv_rise.size() >= 2 && fv_fall.size() >= 1) gap = fv_rise[1] - fv_fall[0];
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got rises %0d want 2", rises); end
        checks++; if (fv_rise.size() != 2) begin errors++; $display("FAIL b2b_frames got %0d want 2", fv_rise.size()); end
        checks++; if (gap < 16) begin errors++; $display("FAIL b2b_vblank got %0d want >=16", gap); end
        checks++; if (FrameCount !== 16'(exp_fc)) begin errors++; $display("FAIL b2b_framecount got %0d want %0d", FrameCount, exp_fc); end
        checks++; if (src.size() != 2) begin errors++; $display("FAIL b2b_unconsumed got %0d want 2", src.size()); end
        checks++; if (pix.size() != 4 || pix[0] !== 24'h000300 || pix[3] !== 24'h000311) begin errors++; $display("FAIL b2b_pixels got %0d beats want 4", pix.size()); end
        checks++; if (Busy !== 1'b0 || ax.tready !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %b tready %b want 0 0", Busy, ax.tready); end
    endtask

    initial begin
        CL_reset  = 1'b1;
        Enable    = 1'b0;
        LineSize  = 16'd0;
        FrameSize = 16'd0;
        ErrClear  = 1'b0;
        drive_head();
        test_reset();
        test_reset_midframe();
        test_basic();
        test_underrun();
        test_resync();
        test_sync_err();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
